// File: rtl/pwm_audio_mixer_if.sv
//------------------------------------------------------------------------------
// pwm_audio_mixer_if : register write/read bus for the PWM audio mixer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pwm_audio_mixer_if #(
    parameter int ADDR_W = 4
);
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [31:0]       i_wr_data;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [31:0]       o_rd_data;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
        input  o_rd_data
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
        output o_rd_data
    );
endinterface

`default_nettype wire

// File: rtl/pwm_audio_mixer.sv
//------------------------------------------------------------------------------
// pwm_audio_mixer : multi-channel square-wave tone generator with PWM mix output
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_audio_mixer #(
    parameter int NUM_CH   = 4,
    parameter int VOL_BITS = 4,
    parameter int DIV_BITS = 20,
    parameter int PWM_BITS = 8
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    pwm_audio_mixer_if.slave    bus,
    output logic                o_aud_en,
    output logic                o_aud_pwm
);
    localparam int MIX_W     = VOL_BITS + $clog2(NUM_CH);
    localparam int SHIFT     = PWM_BITS - MIX_W;
    localparam int CTRL_ADDR = 2 * NUM_CH;

    logic                en_q;
    logic                mute_q;
    logic                en_d;
    logic                w_ctrl_wr;
    logic [DIV_BITS-1:0] w_half [NUM_CH];
    logic [VOL_BITS-1:0] w_vol  [NUM_CH];
    logic [NUM_CH-1:0]   w_lvl;
    logic [MIX_W-1:0]    mix_q;
    logic [MIX_W-1:0]    mix_d;
    logic [PWM_BITS-1:0] pcnt_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] w_tgt;
    logic                pwm_q;
    logic [31:0]         rd_data_q;
    logic [31:0]         rd_data_d;
    logic                w_unused_wdata;

    assign w_unused_wdata = ^bus.i_wr_data;
    assign w_ctrl_wr      = bus.i_wr_en && (int'(bus.i_wr_addr) == CTRL_ADDR);
    // Disable takes effect on the very edge that writes EN=0.
    assign en_d           = w_ctrl_wr ? bus.i_wr_data[0] : en_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q   <= 1'b0;
            mute_q <= 1'b0;
        end else if (w_ctrl_wr) begin
            en_q   <= bus.i_wr_data[0];
            mute_q <= bus.i_wr_data[1];
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_BITS-1:0] half_q;
        logic [VOL_BITS-1:0] vol_q;
        logic [DIV_BITS-1:0] cnt_q;
        logic                lvl_q;
        logic                w_half_wr;
        logic                w_vol_wr;

        assign w_half_wr = bus.i_wr_en && (int'(bus.i_wr_addr) == 2 * c);
        assign w_vol_wr  = bus.i_wr_en && (int'(bus.i_wr_addr) == 2 * c + 1);
        assign w_half[c] = half_q;
        assign w_vol[c]  = vol_q;
        assign w_lvl[c]  = lvl_q;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                half_q <= '0;
                vol_q  <= '0;
            end else begin
                if (w_half_wr) half_q <= bus.i_wr_data[DIV_BITS-1:0];
                if (w_vol_wr)  vol_q  <= bus.i_wr_data[VOL_BITS-1:0];
            end
        end

        // A HALF write restarts the phase and overrides a coincident toggle.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (!en_d) begin
                cnt_q <= '0;
                lvl_q <= 1'b0;
            end else if (w_half_wr) begin
                cnt_q <= '0;
            end else if (en_q) begin
                if (half_q == '0) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else if (cnt_q == half_q - DIV_BITS'(1)) begin
                    cnt_q <= '0;
                    lvl_q <= ~lvl_q;
                end else begin
                    cnt_q <= cnt_q + DIV_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        mix_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_lvl[c]) mix_d = mix_d + MIX_W'(w_vol[c]);
        end
    end

    assign w_tgt = mute_q ? '0 : (PWM_BITS'(mix_q) << SHIFT);

    // Duty is only reloaded on the frame wrap so a frame never changes mid-way.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mix_q  <= '0;
            pcnt_q <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else if (!en_d) begin
            mix_q  <= '0;
            pcnt_q <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else if (en_q) begin
            mix_q  <= mix_d;
            pcnt_q <= pcnt_q + PWM_BITS'(1);
            if (pcnt_q == '1) duty_q <= w_tgt;
            pwm_q  <= (pcnt_q < duty_q);
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(bus.i_rd_addr) == 2 * c)     rd_data_d = 32'(w_half[c]);
            if (int'(bus.i_rd_addr) == 2 * c + 1) rd_data_d = 32'(w_vol[c]);
        end
        if (int'(bus.i_rd_addr) == CTRL_ADDR) rd_data_d = {30'b0, mute_q, en_q};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_data_q <= '0;
        else       rd_data_q <= rd_data_d;
    end

    assign bus.o_rd_data = rd_data_q;
    assign o_aud_en      = en_q;
    assign o_aud_pwm     = pwm_q;
endmodule

`default_nettype wire

// File: tb/tb_pwm_audio_mixer.sv
//------------------------------------------------------------------------------
// tb_pwm_audio_mixer : directed and randomized checks against a closed-form model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_audio_mixer;
    localparam int NUM_CH   = 4;
    localparam int VOL_BITS = 4;
    localparam int DIV_BITS = 20;
    localparam int PWM_BITS = 8;
    localparam int MIX_W    = VOL_BITS + $clog2(NUM_CH);
    localparam int ADDR_W   = $clog2(2 * NUM_CH + 1);
    localparam int FRAME    = 1 << PWM_BITS;
    localparam int SH       = PWM_BITS - MIX_W;
    localparam int CTRL     = 2 * NUM_CH;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic aud_en;
    logic aud_pwm;

    pwm_audio_mixer_if #(.ADDR_W(ADDR_W)) bus();

    pwm_audio_mixer #(
        .NUM_CH(NUM_CH), .VOL_BITS(VOL_BITS), .DIV_BITS(DIV_BITS), .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus), .o_aud_en(aud_en), .o_aud_pwm(aud_pwm)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Scenario description: register contents at enable, plus at most one
    // mid-run VOL write, CTRL(mute) write and HALF0 write (0 = none).
    int H [NUM_CH];
    int V [NUM_CH];
    int mute0;
    int kv, vch, vnew, km, mnew, kh, hnew;
    int k;

    // k counts edges after the enabling edge; values are "after edge kk".
    function automatic int m_lvl(int c, int kk);
        int l;
        if (kk <= 0) return 0;
        if (c == 0 && kh > 0 && kk >= kh) begin
            l = m_lvl(0, kh - 1);
            if (kk == kh) return l;
            if (hnew == 0) return 0;
            return l ^ (((kk - kh) / hnew) % 2);
        end
        if (H[c] == 0) return 0;
        return (kk / H[c]) % 2;
    endfunction

    function automatic int m_vol(int c, int kk);
        return (kv > 0 && c == vch && kk >= kv) ? vnew : V[c];
    endfunction

    function automatic int m_mute(int kk);
        return (km > 0 && kk >= km) ? mnew : mute0;
    endfunction

    function automatic int m_mix(int kk);
        int s = 0;
        if (kk <= 0) return 0;
        for (int c = 0; c < NUM_CH; c++)
            if (m_lvl(c, kk - 1) != 0) s += m_vol(c, kk - 1);
        return s;
    endfunction

    function automatic int m_duty(int kk);
        int m = kk / FRAME;
        if (m == 0) return 0;
        if (m_mute(FRAME * m - 1) != 0) return 0;
        return m_mix(FRAME * m - 1) << SH;
    endfunction

    function automatic int m_pwm(int kk);
        if (kk <= 0) return 0;
        return (((kk - 1) % FRAME) < m_duty(kk - 1)) ? 1 : 0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int addr, int data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = ADDR_W'(addr);
        bus.i_wr_data = 32'(data);
        tick();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic rd(int addr, int exp, string tag);
        bus.i_rd_addr = ADDR_W'(addr);
        tick();
        chk(tag, bus.o_rd_data, exp);
    endtask

    task automatic no_events();
        kv = 0; km = 0; kh = 0;
    endtask

    task automatic start();
        for (int c = 0; c < NUM_CH; c++) begin
            wr(2 * c, H[c]);
            wr(2 * c + 1, V[c]);
        end
        wr(CTRL, mute0 * 2 + 1);
        k = 0;
    endtask

    task automatic run(int n);
        int hi = 0;
        for (int i = 0; i < n; i++) begin
            if (k + 1 == kv) begin
                bus.i_wr_en = 1'b1; bus.i_wr_addr = ADDR_W'(2 * vch + 1); bus.i_wr_data = 32'(vnew);
            end else if (k + 1 == km) begin
                bus.i_wr_en = 1'b1; bus.i_wr_addr = ADDR_W'(CTRL); bus.i_wr_data = 32'(mnew * 2 + 1);
            end else if (k + 1 == kh) begin
                bus.i_wr_en = 1'b1; bus.i_wr_addr = ADDR_W'(0); bus.i_wr_data = 32'(hnew);
            end
            tick();
            k++;
            bus.i_wr_en = 1'b0;
            chk("pwm", aud_pwm, m_pwm(k));
            chk("aud_en_run", aud_en, 1);
            if (aud_pwm === 1'b1) hi++;
            if ((k - 1) % FRAME == FRAME - 1) begin
                chk("frame_high", hi, m_duty(k - 1));
                hi = 0;
            end
        end
    endtask

    task automatic disable_chk();
        wr(CTRL, 0);
        chk("dis_pwm", aud_pwm, 0);
        chk("dis_en", aud_en, 0);
    endtask

    initial begin
        int d;
        bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_rd_addr = '0;
        no_events();
        k = 0;
        repeat (3) tick();
        rstn = 1'b1;

        // Reset state
        for (int a = 0; a < (1 << ADDR_W); a++) rd(a, 0, "reset_rd");
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("reset_en", aud_en, 0);
            chk("reset_pwm", aud_pwm, 0);
        end

        // Register write/readback with masking
        for (int c = 0; c < NUM_CH; c++) begin
            d = $urandom; wr(2 * c, d);     H[c] = d & ((1 << DIV_BITS) - 1); rd(2 * c, H[c], "half_rb");
            d = $urandom; wr(2 * c + 1, d); V[c] = d & ((1 << VOL_BITS) - 1); rd(2 * c + 1, V[c], "vol_rb");
        end
        wr(CTRL, 32'hFFFF_FFFE);
        rd(CTRL, 2, "ctrl_rb");
        chk("mute_no_en", aud_en, 0);
        wr(CTRL, 0);
        rd(CTRL, 0, "ctrl_rb0");
        for (int a = CTRL + 1; a < (1 << ADDR_W); a++) begin
            wr(a, $urandom);
            rd(a, 0, "unmapped_rd");
        end
        for (int c = 0; c < NUM_CH; c++) rd(2 * c, H[c], "half_keep");

        // One-cycle read latency: the write edge still returns the old value
        bus.i_rd_addr = ADDR_W'(0);
        d = 12345;
        wr(0, d);
        chk("rd_lat_old", bus.o_rd_data, H[0]);
        tick();
        chk("rd_lat_new", bus.o_rd_data, d);

        // Single tone HALF0=3, VOL0=15; disable lands on a toggle edge
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 0; V[c] = $urandom_range(0, 15); end
        H[0] = 3; V[0] = 15; mute0 = 0; no_events();
        start(); run(1031); disable_chk();
        start(); run(600); disable_chk();

        // All channels full volume, then mute mid-run
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 1000; V[c] = 15; end
        mute0 = 0; no_events(); km = 1100; mnew = 1;
        start(); run(1791); disable_chk();

        // VOL0 changed at pcnt=100 inside a frame
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 0; V[c] = 15; end
        H[0] = 400; mute0 = 0; no_events(); kv = 2 * FRAME + 101; vch = 0; vnew = 5;
        start(); run(1100); disable_chk();

        // HALF0 rewritten exactly on its terminal count
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 0; V[c] = 0; end
        H[0] = 100; V[0] = 15; mute0 = 0; no_events(); kh = 300; hnew = 100;
        start(); run(1100); disable_chk();

        // Randomized scenarios
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                H[c] = $urandom_range(0, 600);
                V[c] = $urandom_range(0, 15);
            end
            mute0 = ($urandom_range(0, 3) == 0) ? 1 : 0;
            no_events();
            kv = $urandom_range(1, 300); vch = $urandom_range(0, NUM_CH - 1); vnew = $urandom_range(0, 15);
            kh = kv + $urandom_range(1, 300); hnew = $urandom_range(0, 400);
            km = kh + $urandom_range(1, 300); mnew = $urandom_range(0, 1);
            start(); run(1280); disable_chk();
        end

        // Registers survive EN=0
        for (int c = 1; c < NUM_CH; c++) rd(2 * c, H[c], "half_after_dis");

        // Asynchronous reset pulse mid-operation
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 7 + c; V[c] = 9; end
        mute0 = 0; no_events();
        start(); run(300);
        rstn = 1'b0;
        #1;
        chk("arst_en", aud_en, 0);
        chk("arst_pwm", aud_pwm, 0);
        chk("arst_rd", bus.o_rd_data, 0);
        tick();
        rstn = 1'b1;
        for (int a = 0; a <= CTRL; a++) rd(a, 0, "post_rst_rd");
        for (int c = 0; c < NUM_CH; c++) begin H[c] = 0; V[c] = 0; end
        no_events();
        wr(CTRL, 1); k = 0;
        run(600);
        disable_chk();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

`default_nettype wire
